// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift_sequencer load/unload sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDrain,
    StDone
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_sequencer_if.sv
// Load/capture handshakes plus the serial link to the downstream shift register.
// SHIFT_SEQ_PARITY_EN adds the cap_parity signal.
interface shift_sequencer_if #(
  parameter int unsigned WIDTH = 64
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             load_dir;
  logic             ser_out;
  logic             shift_left;
  logic             shift_right;
  logic             ser_in;
  logic             cap_valid;
  logic             cap_ready;
  logic [WIDTH-1:0] cap_data;
  logic             busy;
`ifdef SHIFT_SEQ_PARITY_EN
  logic             cap_parity;
`endif

  modport master (
    output load_valid,
    output load_data,
    output load_dir,
    output ser_in,
    output cap_ready,
    input  load_ready,
    input  ser_out,
    input  shift_left,
    input  shift_right,
    input  cap_valid,
    input  cap_data,
`ifdef SHIFT_SEQ_PARITY_EN
    input  cap_parity,
`endif
    input  busy
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_dir,
    input  ser_in,
    input  cap_ready,
    output load_ready,
    output ser_out,
    output shift_left,
    output shift_right,
    output cap_valid,
    output cap_data,
`ifdef SHIFT_SEQ_PARITY_EN
    output cap_parity,
`endif
    output busy
  );

endinterface

// File: rtl/shift_seq_deser.sv
// Direction-aware capture register: rebuilds the downstream register's old contents
// from the bits it shifts out.
module shift_seq_deser
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_dir,
  input  logic             i_ser_in,
  output logic [WIDTH-1:0] o_cap_data
);

  logic [WIDTH-1:0] r_cap;

  // Left shifts emit MSB first, so it enters at the bottom and works its way up;
  // right shifts emit LSB first, so it enters at the top and works its way down.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cap <= '0;
    end else if (i_enable) begin
      if (i_dir == DIR_RIGHT) begin
        r_cap <= {i_ser_in, r_cap[WIDTH-1:1]};
      end else begin
        r_cap <= {r_cap[WIDTH-2:0], i_ser_in};
      end
    end
  end

  assign o_cap_data = r_cap;

endmodule

// File: rtl/shift_sequencer.sv
// Streams a parallel word into a downstream serial shift register while capturing
// its previous contents. Define SHIFT_SEQ_PARITY_EN to add the cap_parity output.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input logic              clock,
  input logic              reset,
  shift_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_tx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_live;

  logic             w_load_ready;
  logic             w_accept;
  logic             w_shift_left;
  logic             w_shift_right;
  logic             w_cap_en;
  logic             w_cap_valid;
  logic             w_busy;
  logic [WIDTH-1:0] w_cap_data;

  assign w_accept = bus.load_valid & w_load_ready;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StShift;
      StShift: if (r_cnt == CNT_MAX) w_state_next = StDrain;
      StDrain: w_state_next = StDone;
      StDone:  if (bus.cap_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs, decoded from registered state only
  always_comb begin
    w_load_ready  = 1'b0;
    w_shift_left  = 1'b0;
    w_shift_right = 1'b0;
    w_cap_en      = 1'b0;
    w_cap_valid   = 1'b0;
    w_busy        = 1'b0;
    unique case (r_state)
      StIdle: begin
        // r_live keeps load_ready low while reset is held.
        w_load_ready = r_live;
      end
      StShift: begin
        w_busy        = 1'b1;
        w_shift_left  = (r_dir == DIR_LEFT);
        w_shift_right = (r_dir == DIR_RIGHT);
        // Downstream out is registered: nothing useful arrives in the first cycle.
        w_cap_en      = (r_cnt != '0);
      end
      StDrain: begin
        w_busy   = 1'b1;
        w_cap_en = 1'b1;
      end
      StDone: begin
        w_busy      = 1'b1;
        w_cap_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Tx buffer, bit counter and latched direction
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx   <= '0;
      r_cnt  <= '0;
      r_dir  <= DIR_LEFT;
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (r_state == StIdle) begin
        if (w_accept) begin
          r_tx  <= bus.load_data;
          r_dir <= bus.load_dir;
          r_cnt <= '0;
        end
      end else if (r_state == StShift) begin
        if (r_dir == DIR_RIGHT) begin
          r_tx <= {1'b0, r_tx[WIDTH-1:1]};
        end else begin
          r_tx <= {r_tx[WIDTH-2:0], 1'b0};
        end
        if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  shift_seq_deser #(
    .WIDTH (WIDTH)
  ) u_deser (
    .clock      (clock),
    .reset      (reset),
    .i_enable   (w_cap_en),
    .i_dir      (r_dir),
    .i_ser_in   (bus.ser_in),
    .o_cap_data (w_cap_data)
  );

`ifdef SHIFT_SEQ_PARITY_EN
  logic r_parity;
  logic w_drop_bit;
  logic w_parity_next;

  // Parity of the word the final capture will produce: swap the dropped bit for ser_in.
  assign w_drop_bit    = (r_dir == DIR_RIGHT) ? w_cap_data[0] : w_cap_data[WIDTH-1];
  assign w_parity_next = (^w_cap_data) ^ w_drop_bit ^ bus.ser_in;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else if (r_state == StDrain) begin
      r_parity <= w_parity_next;
    end
  end

  assign bus.cap_parity = r_parity;
`endif

  assign bus.load_ready  = w_load_ready;
  assign bus.shift_left  = w_shift_left;
  assign bus.shift_right = w_shift_right;
  assign bus.ser_out     = (r_dir == DIR_RIGHT) ? r_tx[0] : r_tx[WIDTH-1];
  assign bus.cap_valid   = w_cap_valid;
  assign bus.cap_data    = w_cap_data;
  assign bus.busy        = w_busy;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer with a 64-bit downstream shift register model; the expected
// capture is simply the word loaded before (0 after reset).
module tb_shift_sequencer;

  localparam int unsigned W = 64;

  logic clock;
  logic reset;

  shift_sequencer_if #(.WIDTH(W)) bus ();

  shift_sequencer #(
    .WIDTH (W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream 64-bit serial shift register with registered serial output.
  logic [W-1:0] dreg;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      dreg       <= '0;
      bus.ser_in <= 1'b0;
    end else if (bus.shift_left) begin
      dreg       <= {dreg[W-2:0], bus.ser_out};
      bus.ser_in <= dreg[W-1];
    end else if (bus.shift_right) begin
      dreg       <= {bus.ser_out, dreg[W-1:1]};
      bus.ser_in <= dreg[0];
    end
  end

  int unsigned  n_cmp;
  int unsigned  n_bad;
  logic [W-1:0] prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full load/capture transaction. bp: cycles of cap_ready low once cap_valid is up.
  // inject: pulse an all-ones load mid-shift. rst_at: SHIFT cycle index to reset in (-1 none).
  task automatic do_load(input logic [W-1:0] w, input logic d, input int bp,
                         input bit inject, input int rst_at);
    int           t;
    int           k;
    int           nl;
    int           nr;
    int           bad;
    logic         exp_bit;
    logic [W-1:0] snap;

    t = 0;
    while (!bus.load_ready && t < 50) begin
      step();
      t++;
    end
    chk("load_ready before load", 64'(bus.load_ready), 64'd1);

    bus.load_valid = 1'b1;
    bus.load_data  = w;
    bus.load_dir   = d;
    step();
    bus.load_valid = 1'b0;
    bus.load_data  = {$urandom, $urandom};
    bus.load_dir   = ~d;

    k   = 0;
    nl  = 0;
    nr  = 0;
    bad = 0;
    while (k < 200) begin
      if (bus.cap_valid) break;
      if (k == rst_at) begin
        #1;
        reset = 1'b0;
        #1;
        chk("reset shift enables", 64'({bus.shift_left, bus.shift_right}), 64'd0);
        chk("reset cap_valid/busy/load_ready",
            64'({bus.cap_valid, bus.busy, bus.load_ready}), 64'd0);
        chk("reset cap_data", bus.cap_data, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        chk("load_ready after reset release", 64'(bus.load_ready), 64'd1);
        prev = '0;
        return;
      end
      nl += int'(bus.shift_left);
      nr += int'(bus.shift_right);
      if (k < W) begin
        exp_bit = d ? w[k] : w[W-1-k];
        if (bus.ser_out !== exp_bit) bad++;
      end
      if (inject && k == 10) begin
        bus.load_valid = 1'b1;
        bus.load_data  = '1;
        if (bus.load_ready !== 1'b0) bad++;
      end else begin
        bus.load_valid = 1'b0;
      end
      step();
      k++;
    end
    bus.load_valid = 1'b0;

    chk("cap_valid latency", 64'(k), 64'(W + 1));
    chk("active shift enable cycles", 64'(d ? nr : nl), 64'(W));
    chk("inactive shift enable cycles", 64'(d ? nl : nr), 64'd0);
    chk("ser_out bit errors", 64'(bad), 64'd0);
    chk("cap_data", bus.cap_data, prev);
`ifdef SHIFT_SEQ_PARITY_EN
    chk("cap_parity", 64'(bus.cap_parity), 64'(^prev));
`endif

    snap = bus.cap_data;
    bad  = 0;
    for (int i = 0; i < bp; i++) begin
      bus.cap_ready = 1'b0;
      step();
      if (bus.cap_valid !== 1'b1 || bus.cap_data !== snap || bus.load_ready !== 1'b0) bad++;
    end
    if (bp > 0) chk("backpressure hold", 64'(bad), 64'd0);

    bus.cap_ready = 1'b1;
    step();
    bus.cap_ready = 1'b0;
    chk("idle after cap_ready", 64'({bus.load_ready, bus.busy, bus.cap_valid}), 64'b100);
    prev = w;
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    prev           = '0;
    reset          = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_dir   = 1'b0;
    bus.cap_ready  = 1'b0;

    #12;
    chk("reset outputs", 64'({bus.load_ready, bus.busy, bus.cap_valid, bus.shift_left,
                              bus.shift_right, bus.ser_out}), 64'd0);
    chk("reset cap_data", bus.cap_data, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("load_ready first edge after release", 64'(bus.load_ready), 64'd1);

    // Left, two passes
    do_load(64'hDEADBEEF_01234567, 1'b0, 0, 1'b0, -1);
    do_load(64'h0,                 1'b0, 0, 1'b0, -1);
    // Right, two passes
    do_load(64'hDEADBEEF_01234567, 1'b1, 0, 1'b0, -1);
    do_load(64'h0,                 1'b1, 0, 1'b0, -1);
    // Backpressure, then parity words 1 and 3
    do_load(64'h1,                 1'b0, 10, 1'b0, -1);
    do_load(64'h3,                 1'b1, 0, 1'b0, -1);
    do_load(64'hA5A5_0F0F_1234_8001, 1'b0, 2, 1'b0, -1);
    // Reset during SHIFT cycle 20, then a full load
    do_load(64'hCAFE_F00D_5555_AAAA, 1'b1, 0, 1'b0, 19);
    do_load(64'h0123_4567_89AB_CDEF, 1'b0, 0, 1'b0, -1);
    // Load offered while busy
    do_load(64'h8000_0000_0000_0001, 1'b1, 0, 1'b1, -1);
    do_load(64'h7777_1111_2222_3333, 1'b0, 0, 1'b1, -1);

    for (int i = 0; i < 6; i++) begin
      do_load({$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, -1);
    end
    do_load(64'h0, 1'b0, 0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Load/unload sequencer that sits directly upstream of the 64-bit serial shift register and drives its `in`, `shiftLeft` and `shiftRight` inputs. It also consumes that register's serial `out`.

- Accepts a parallel word plus a direction over a valid/ready handshake.
- Streams the word into the register one bit per clock, MSB- or LSB-first as the direction requires.
- Simultaneously deserialises the bits shifted out, returning the register's previous contents as a parallel word over a second valid/ready handshake.

## Interface

Parameters:
- WIDTH, 64, word length; must equal the downstream register length (≥2)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- load_valid  in  1  load word offered
- load_ready  out  1  sequencer idle, accepts load
- load_data  in  WIDTH  word to shift in
- load_dir  in  1  0 = left (feeds shiftLeft), 1 = right (feeds shiftRight)
- ser_out  out  1  serial bit to downstream `in`
- shift_left  out  1  to downstream shiftLeft
- shift_right  out  1  to downstream shiftRight
- ser_in  in  1  from downstream `out`
- cap_valid  out  1  captured word available
- cap_ready  in  1  consumer takes captured word
- cap_data  out  WIDTH  previous downstream contents
- busy  out  1  state ≠ IDLE

## Operation

The block has four states: IDLE, SHIFT, DRAIN and DONE.

- **IDLE**
  - load_ready=1.
  - On load_valid&load_ready: register load_data into the tx buffer and latch the direction, clear the bit counter, then go to SHIFT.
- **SHIFT** (exactly WIDTH cycles)
  - The active direction's shift enable is 1 and the other is 0.
  - ser_out = tx head bit:
    - left: load_data[WIDTH-1] first, down to [0];
    - right: load_data[0] first, up to [WIDTH-1].
  - The tx buffer advances by one bit every cycle.
  - When the counter reaches WIDTH-1, go to DRAIN.
- **DRAIN** (1 cycle)
  - No shift enable is asserted.
  - Samples the final returned bit.
  - Then go to DONE.
- **DONE**
  - cap_valid=1 and cap_data is stable.
  - On cap_ready, go to IDLE.
- **Capture rule**
  - The downstream `out` is registered, so the bit from shift edge k is visible after edge k. ser_in is therefore sampled at SHIFT cycles 2..WIDTH and in the DRAIN cycle: WIDTH samples.
  - Left: cap <= {cap[WIDTH-2:0], ser_in}.
  - Right: cap <= {ser_in, cap[WIDTH-1:1]}.
  - Result: cap_data equals the downstream contents before the load, bit-for-bit.
- **Ignored inputs**
  - load_valid outside IDLE is ignored and the input word is not sampled.
  - cap_ready outside DONE is ignored.
- **Counter width:** $clog2(WIDTH); no wrap beyond WIDTH-1.

## Timing

- Edge E0 accepts the load.
- Shift enable is high in the cycles after edges E0..E(WIDTH-1), so downstream shifts occur at edges E1..EWIDTH.
- cap_valid rises after edge E(WIDTH+1): latency WIDTH+1 cycles from acceptance.
- Minimum load-to-load interval is WIDTH+3 cycles, with cap_ready held high.
- Shift enables and ser_out are registered or decoded from registered state only; there is no combinational path from any input.
- load_ready and busy are decoded from state.
- **Reset**
  - All outputs 0, state IDLE, buffers 0.
  - Asserting reset mid-operation deasserts shift enables immediately and discards the partial capture.
  - load_ready=1 from the first edge after release.
- cap_valid, once high, holds until the cap_valid&cap_ready edge.

## Configuration

- SHIFT_SEQ_PARITY_EN defined:
  - Adds output `cap_parity` (1 bit) = XOR of all cap_data bits.
  - Registered in the DRAIN→DONE transition and valid whenever cap_valid=1.
  - Reset value 0.
- Not defined: the port and its logic are absent; everything else is unchanged.

## Structure

- Package shift_seq_pkg holds:
  - state typedef (IDLE, SHIFT, DRAIN, DONE);
  - constants DIR_LEFT=1'b0 and DIR_RIGHT=1'b1.
- One sub-module, shift_seq_deser: the direction-aware capture shift register, with inputs enable, dir and ser_in and output cap_data.
- The FSM, counter and tx buffer live in shift_sequencer.

## Test plan

The bench instantiates the downstream register model with WIDTH=64.

- **Left load, two passes.** Reset, then load 64'hDEADBEEF_01234567 left, then load 64'h0 left. Required response:
  - first cap_data=64'h0;
  - second cap_data=64'hDEADBEEF_01234567;
  - shift_left high exactly 64 cycles per load, shift_right never high.
- **Right load, two passes.** The same two loads with dir=1. Required response:
  - identical cap_data results;
  - only shift_right pulses.
- **Backpressure.** cap_ready held low for 10 cycles after cap_valid. Required response:
  - cap_valid stays 1 and cap_data is unchanged;
  - load_ready=0 throughout;
  - IDLE one cycle after cap_ready=1.
- **Reset mid-shift.** Assert reset during SHIFT cycle 20. Required response:
  - shift enables, cap_valid and busy go to 0 without a clock edge;
  - load_ready=1 after release;
  - the next full load completes normally.
- **Load while busy.** load_valid pulsed with 64'hFFFF_FFFF_FFFF_FFFF during SHIFT. Required response:
  - ignored;
  - the in-flight word's bits on ser_out are unchanged.
- **Parity (SHIFT_SEQ_PARITY_EN).** Capture 64'h1, then capture 64'h3. Required response: cap_parity=1, then cap_parity=0.
